// File: rtl/store_buffer_coalescing_pkg.sv
// rtl/store_buffer_coalescing_pkg.sv - shared defaults and width helpers for the store buffer
package store_buffer_coalescing_pkg;

    localparam int SB_ADDR_WIDTH = 32;
    localparam int SB_DATA_WIDTH = 32;
    localparam int SB_NLINES     = 4;
    localparam int SB_COALESCE   = 1;

    function automatic int be_width(input int data_width);
        return data_width / 8;
    endfunction

    function automatic int ofs_width(input int data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/sb_fwd_select.sv
// rtl/sb_fwd_select.sv - picks the youngest matching entry by walking age order from the head
module sb_fwd_select
    import store_buffer_coalescing_pkg::*;
#(
    parameter int NLINES = SB_NLINES,
    localparam int PW = $clog2(NLINES)
) (
    input  logic [NLINES-1:0] match,
    input  logic [PW-1:0]     head_idx,
    output logic [NLINES-1:0] onehot,
    output logic [PW-1:0]     sel,
    output logic              any
);

    logic [PW-1:0] idx;

    // Later ages overwrite earlier ones, so the last match seen is the one nearest the tail.
    always_comb begin
        onehot = '0;
        sel    = '0;
        any    = 1'b0;
        idx    = '0;
        for (int age = 0; age < NLINES; age++) begin
            idx = head_idx + PW'(age);
            if (match[idx]) begin
                sel = idx;
                any = 1'b1;
            end
        end
        if (any) begin
            onehot[sel] = 1'b1;
        end
    end

endmodule

// File: rtl/store_buffer_coalescing.sv
// rtl/store_buffer_coalescing.sv - coalescing store buffer with load forwarding and cache drain
module store_buffer_coalescing
    import store_buffer_coalescing_pkg::*;
#(
    parameter int ADDR_WIDTH = SB_ADDR_WIDTH,
    parameter int DATA_WIDTH = SB_DATA_WIDTH,
    parameter int NLINES     = SB_NLINES,
    parameter int COALESCE   = SB_COALESCE,
    localparam int BE_W = be_width(DATA_WIDTH),
    localparam int PW   = $clog2(NLINES)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  st_valid,
    input  logic [ADDR_WIDTH-1:0] st_addr,
    input  logic [DATA_WIDTH-1:0] st_data,
    input  logic [BE_W-1:0]       st_be,
    output logic                  st_ready,
    input  logic                  ld_valid,
    input  logic [ADDR_WIDTH-1:0] ld_addr,
    input  logic [BE_W-1:0]       ld_be,
    output logic [DATA_WIDTH-1:0] ld_data,
    output logic                  ld_hit,
    output logic                  ld_partial,
    output logic                  drain_valid,
    output logic [ADDR_WIDTH-1:0] drain_addr,
    output logic [DATA_WIDTH-1:0] drain_data,
    output logic [BE_W-1:0]       drain_be,
    input  logic                  drain_ready,
    output logic [PW:0]           count,
    output logic                  full,
    output logic                  empty
);

    logic [ADDR_WIDTH-1:0] e_addr [NLINES];
    logic [DATA_WIDTH-1:0] e_data [NLINES];
    logic [BE_W-1:0]       e_be   [NLINES];
    logic [NLINES-1:0]     e_valid;
    logic [PW:0]           head;
    logic [PW:0]           tail;
    logic [PW-1:0]         head_idx;
    logic [PW-1:0]         tail_idx;
    logic [PW-1:0]         last_idx;
    logic                  coalesce_hit;
    logic                  st_fire;
    logic                  do_alloc;
    logic                  do_merge;
    logic                  do_pop;
    logic [DATA_WIDTH-1:0] st_mask;
    logic [NLINES-1:0]     ld_match;
    logic [NLINES-1:0]     ld_onehot;
    logic [PW-1:0]         ld_sel;
    logic                  ld_any;
    logic [DATA_WIDTH-1:0] fwd_word;

    function automatic logic [ADDR_WIDTH-1:0] word_of(input logic [ADDR_WIDTH-1:0] a);
        return a & ~ADDR_WIDTH'(BE_W - 1);
    endfunction

    function automatic logic [DATA_WIDTH-1:0] lane_mask(input logic [BE_W-1:0] be);
        logic [DATA_WIDTH-1:0] m;
        m = '0;
        for (int i = 0; i < BE_W; i++) begin
            m[i*8 +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

    assign head_idx = head[PW-1:0];
    assign tail_idx = tail[PW-1:0];
    assign last_idx = tail_idx - PW'(1);
    assign count    = tail - head;
    assign empty    = (head == tail);
    assign full     = (head_idx == tail_idx) && (head[PW] != tail[PW]);

    // Requiring two entries keeps merges off the head, so st_ready never depends on drain_ready.
    assign coalesce_hit = (COALESCE != 0) && (count >= (PW+1)'(2)) && e_valid[last_idx]
                          && (e_addr[last_idx] == word_of(st_addr));
    assign st_ready = !full || coalesce_hit;
    assign st_fire  = st_valid && st_ready && (st_be != '0);
    assign do_merge = st_fire && coalesce_hit;
    assign do_alloc = st_fire && !coalesce_hit;
    assign do_pop   = drain_valid && drain_ready;
    assign st_mask  = lane_mask(st_be);

    // Entry data is stored with disabled lanes zeroed, so forwarding and drain need no masking.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            head    <= '0;
            tail    <= '0;
            e_valid <= '0;
            for (int i = 0; i < NLINES; i++) begin
                e_addr[i] <= '0;
                e_data[i] <= '0;
                e_be[i]   <= '0;
            end
        end else begin
            if (do_alloc) begin
                e_addr[tail_idx]  <= word_of(st_addr);
                e_data[tail_idx]  <= st_data & st_mask;
                e_be[tail_idx]    <= st_be;
                e_valid[tail_idx] <= 1'b1;
                tail              <= tail + (PW+1)'(1);
            end
            if (do_merge) begin
                e_data[last_idx] <= (e_data[last_idx] & ~st_mask) | (st_data & st_mask);
                e_be[last_idx]   <= e_be[last_idx] | st_be;
            end
            if (do_pop) begin
                e_valid[head_idx] <= 1'b0;
                head              <= head + (PW+1)'(1);
            end
        end
    end

    assign drain_valid = !empty;
    assign drain_addr  = empty ? '0 : e_addr[head_idx];
    assign drain_data  = empty ? '0 : e_data[head_idx];
    assign drain_be    = empty ? '0 : e_be[head_idx];

    always_comb begin
        ld_match = '0;
        for (int i = 0; i < NLINES; i++) begin
            ld_match[i] = ld_valid && e_valid[i] && (e_addr[i] == word_of(ld_addr));
        end
    end

    sb_fwd_select #(
        .NLINES (NLINES)
    ) u_fwd_select (
        .match    (ld_match),
        .head_idx (head_idx),
        .onehot   (ld_onehot),
        .sel      (ld_sel),
        .any      (ld_any)
    );

    always_comb begin
        fwd_word = '0;
        for (int i = 0; i < NLINES; i++) begin
            if (ld_onehot[i]) begin
                fwd_word = fwd_word | e_data[i];
            end
        end
    end

    assign ld_hit     = ld_any && ((e_be[ld_sel] & ld_be) == ld_be);
    assign ld_partial = ld_any && !ld_hit;
    assign ld_data    = ld_hit ? fwd_word : '0;

endmodule

// File: tb/tb_store_buffer_coalescing.sv
// tb/tb_store_buffer_coalescing.sv - queue-model bench for the coalescing store buffer
module tb_store_buffer_coalescing;

    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        st_valid = 1'b0;
    logic [31:0] st_addr = '0;
    logic [31:0] st_data = '0;
    logic [3:0]  st_be = '0;
    logic        st_ready;
    logic        ld_valid = 1'b0;
    logic [31:0] ld_addr = '0;
    logic [3:0]  ld_be = '0;
    logic [31:0] ld_data;
    logic        ld_hit;
    logic        ld_partial;
    logic        drain_valid;
    logic [31:0] drain_addr;
    logic [31:0] drain_data;
    logic [3:0]  drain_be;
    logic        drain_ready = 1'b0;
    logic [2:0]  count;
    logic        full;
    logic        empty;

    int checks = 0;
    int failures = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] d;
        logic [3:0]  be;
    } ent_t;
    ent_t q[$];

    always #5 clk = ~clk;

    store_buffer_coalescing dut (
        .clk         (clk),
        .reset       (reset),
        .st_valid    (st_valid),
        .st_addr     (st_addr),
        .st_data     (st_data),
        .st_be       (st_be),
        .st_ready    (st_ready),
        .ld_valid    (ld_valid),
        .ld_addr     (ld_addr),
        .ld_be       (ld_be),
        .ld_data     (ld_data),
        .ld_hit      (ld_hit),
        .ld_partial  (ld_partial),
        .drain_valid (drain_valid),
        .drain_addr  (drain_addr),
        .drain_data  (drain_data),
        .drain_be    (drain_be),
        .drain_ready (drain_ready),
        .count       (count),
        .full        (full),
        .empty       (empty)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] word(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    function automatic logic [31:0] lanes(input logic [3:0] be);
        logic [31:0] m;
        for (int i = 0; i < 4; i++) m[i*8 +: 8] = {8{be[i]}};
        return m;
    endfunction

    function automatic bit merge_now();
        return (q.size() >= 2) && (q[q.size()-1].a == word(st_addr));
    endfunction

    task automatic check_model();
        int y;
        logic eh, ep;
        logic [31:0] eld, ea, ed;
        logic [3:0] eb;
        y = -1;
        if (ld_valid)
            for (int i = 0; i < q.size(); i++)
                if (q[i].a == word(ld_addr)) y = i;
        eh = 1'b0; ep = 1'b0; eld = '0;
        if (y >= 0) begin
            if ((q[y].be & ld_be) == ld_be) begin
                eh = 1'b1;
                eld = q[y].d;
            end else begin
                ep = 1'b1;
            end
        end
        ea = '0; ed = '0; eb = '0;
        if (q.size() > 0) begin
            ea = q[0].a; ed = q[0].d; eb = q[0].be;
        end
        chk("count", 64'(count), 64'(q.size()));
        chk("empty", 64'(empty), 64'(q.size() == 0));
        chk("full", 64'(full), 64'(q.size() == N));
        chk("st_ready", 64'(st_ready), 64'((q.size() < N) || merge_now()));
        chk("drain_valid", 64'(drain_valid), 64'(q.size() > 0));
        chk("drain_addr", 64'(drain_addr), 64'(ea));
        chk("drain_data", 64'(drain_data), 64'(ed));
        chk("drain_be", 64'(drain_be), 64'(eb));
        chk("ld_hit", 64'(ld_hit), 64'(eh));
        chk("ld_partial", 64'(ld_partial), 64'(ep));
        chk("ld_data", 64'(ld_data), 64'(eld));
    endtask

    task automatic step_model();
        bit mg, rdy, pop;
        ent_t e;
        mg  = merge_now();
        rdy = (q.size() < N) || mg;
        pop = drain_ready && (q.size() > 0);
        if (st_valid && rdy && st_be != 4'h0) begin
            if (mg) begin
                e = q[q.size()-1];
                e.d = (e.d & ~lanes(st_be)) | (st_data & lanes(st_be));
                e.be = e.be | st_be;
                q[q.size()-1] = e;
            end else begin
                e.a = word(st_addr);
                e.d = st_data & lanes(st_be);
                e.be = st_be;
                q.push_back(e);
            end
        end
        if (pop) void'(q.pop_front());
    endtask

    task automatic cyc(input bit sv, input logic [31:0] sa, input logic [31:0] sd, input logic [3:0] sb,
                       input bit lv, input logic [31:0] la, input logic [3:0] lb, input bit dr);
        st_valid = sv; st_addr = sa; st_data = sd; st_be = sb;
        ld_valid = lv; ld_addr = la; ld_be = lb; drain_ready = dr;
        #1;
        check_model();
        @(posedge clk);
        step_model();
        @(negedge clk);
    endtask

    task automatic idle();
        st_valid = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
        ld_valid = 1'b0; ld_addr = '0; ld_be = '0; drain_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        q.delete();
        #1;
        check_model();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr();
        return 32'h40 + 32'($urandom_range(0, 4)) * 4 + 32'($urandom_range(0, 3));
    endfunction

    initial begin
        #1;
        chk("reset_count", 64'(count), 64'h0);
        chk("reset_drain_valid", 64'(drain_valid), 64'h0);
        chk("reset_st_ready", 64'(st_ready), 64'h1);
        chk("reset_empty", 64'(empty), 64'h1);
        check_model();
        @(negedge clk);
        reset = 1'b0;

        cyc(1, 32'hAA, 32'h0000DDDD, 4'hF, 0, 0, 0, 0);
        idle(); #1;
        chk("t1_count", 64'(count), 64'h1);
        chk("t1_drain_valid", 64'(drain_valid), 64'h1);
        chk("t1_drain_addr", 64'(drain_addr), 64'hA8);
        chk("t1_drain_data", 64'(drain_data), 64'h0000DDDD);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        cyc(1, 32'hB0, 32'h1111, 4'h3, 0, 0, 0, 0);
        cyc(1, 32'hC0, 32'h22, 4'h1, 0, 0, 0, 0);
        cyc(1, 32'hC0, 32'h3300, 4'h2, 0, 0, 0, 0);
        idle(); ld_valid = 1'b1; ld_addr = 32'hC0; ld_be = 4'h3; #1;
        chk("t2_count", 64'(count), 64'h2);
        chk("t2_ld_hit", 64'(ld_hit), 64'h1);
        chk("t2_ld_data", 64'(ld_data), 64'h3322);
        cyc(0, 0, 0, 0, 1, 32'hC0, 4'h3, 1);
        cyc(0, 0, 0, 0, 1, 32'hC0, 4'h3, 1);

        cyc(1, 32'hB0, 32'hAABBCCDD, 4'hF, 0, 0, 0, 0);
        cyc(1, 32'hC4, 32'h1, 4'hF, 0, 0, 0, 0);
        cyc(1, 32'hB0, 32'h77, 4'h1, 0, 0, 0, 0);
        idle(); ld_valid = 1'b1; ld_addr = 32'hB0; ld_be = 4'h3; #1;
        chk("t3_ld_partial", 64'(ld_partial), 64'h1);
        chk("t3_ld_hit", 64'(ld_hit), 64'h0);
        ld_be = 4'h0; #1;
        chk("t3_zero_be_hit", 64'(ld_hit), 64'h1);
        chk("t3_zero_be_data", 64'(ld_data), 64'h77);
        cyc(0, 0, 0, 0, 1, 32'hB0, 4'h3, 0);

        idle();
        reset = 1'b1; #1;
        chk("t6_count", 64'(count), 64'h0);
        chk("t6_drain_valid", 64'(drain_valid), 64'h0);
        chk("t6_drain_addr", 64'(drain_addr), 64'h0);
        chk("t6_empty", 64'(empty), 64'h1);
        do_reset();

        for (int i = 0; i < N; i++)
            cyc(1, 32'h100 + 32'(i) * 4, 32'(i + 1), 4'hF, 0, 0, 0, 0);
        idle(); st_valid = 1'b1; st_addr = 32'h110; st_be = 4'hF; #1;
        chk("t4_full", 64'(full), 64'h1);
        chk("t4_st_ready", 64'(st_ready), 64'h0);
        st_addr = 32'h10C; #1;
        chk("t4_merge_when_full", 64'(st_ready), 64'h1);
        cyc(1, 32'h10C, 32'hEE, 4'h1, 1, 32'h10C, 4'hF, 0);
        cyc(1, 32'h110, 32'h5, 4'hF, 0, 0, 0, 1);
        idle(); #1;
        chk("t4_count_after_pop", 64'(count), 64'h3);
        chk("t4_full_after_pop", 64'(full), 64'h0);
        chk("t4_head_order", 64'(drain_addr), 64'h104);
        cyc(1, 32'h110, 32'h5, 4'hF, 0, 0, 0, 0);
        idle(); #1;
        chk("t4_count_refill", 64'(count), 64'h4);
        for (int i = 0; i < N; i++) cyc(0, 0, 0, 0, 0, 0, 0, 1);

        cyc(1, 32'h200, 32'h11, 4'h1, 0, 0, 0, 0);
        cyc(1, 32'h200, 32'h2200, 4'h2, 0, 0, 0, 0);
        idle(); #1;
        chk("t5_count", 64'(count), 64'h2);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 0, 0, 0, 1);

        for (int n = 0; n < 3000; n++) begin
            if ($urandom_range(0, 399) == 0) begin
                idle();
                do_reset();
            end
            cyc($urandom_range(0, 9) < 7, rand_addr(), $urandom, 4'($urandom),
                $urandom_range(0, 1) == 1, rand_addr(), 4'($urandom), $urandom_range(0, 9) < 4);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
